// File: rtl/oled_volume_bar.sv
// rtl/oled_volume_bar.sv - peak-window volume meter rendered as a vertical bar for a 96x64 RGB565 panel
module oled_volume_bar #(
  parameter int WINDOW     = 4000,
  parameter int MIC_OFFSET = 2048,
  parameter int BAR_X0     = 40,
  parameter int BAR_X1     = 55
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [11:0] i_mic_in,
  input  logic        i_mic_valid,
  input  logic        i_frame_begin,
  input  logic [12:0] i_pixel_index,
  output logic [15:0] o_pixel_data,
  output logic [3:0]  o_level
);

  localparam int              CW      = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]   LP_LAST = CW'(WINDOW - 1);
  localparam logic [11:0]     LP_OFF  = 12'(MIC_OFFSET);
  localparam logic [12:0]     LP_X0   = 13'(BAR_X0);
  localparam logic [12:0]     LP_X1   = 13'(BAR_X1);

  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_BLACK  = 16'h0000;

  logic [CW-1:0] r_cnt;
  logic [11:0]   r_peak;
  logic [3:0]    r_level;
  logic [3:0]    r_disp_level;
  logic [15:0]   r_pixel_data;

  // Peak including the sample currently on the bus, so the closing strobe counts.
  logic [11:0] w_pk;
  logic [11:0] w_diff;
  logic [11:0] w_sh;
  logic [3:0]  w_new_level;
  assign w_pk        = (i_mic_in > r_peak) ? i_mic_in : r_peak;
  assign w_diff      = w_pk - LP_OFF;
  assign w_sh        = w_diff >> 7;
  assign w_new_level = (w_pk <= LP_OFF) ? 4'd0 :
                       (w_sh > 12'd15)  ? 4'd15 : w_sh[3:0];

  // Peak tracking and level quantisation over WINDOW strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_peak  <= '0;
      r_level <= '0;
    end else if (i_mic_valid) begin
      if (r_cnt == LP_LAST) begin
        r_level <= w_new_level;
        r_peak  <= '0;
        r_cnt   <= '0;
      end else begin
        r_peak <= w_pk;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Displayed level only changes at frame start; the old level wins on a same-cycle update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_disp_level <= '0;
    end else if (i_frame_begin) begin
      r_disp_level <= r_level;
    end
  end

  // Pixel coordinates; y >= 64 also covers out-of-panel indices.
  logic [12:0] w_x;
  logic [12:0] w_y;
  logic [12:0] w_top;
  logic        w_lit;
  logic [15:0] w_colour;
  assign w_x   = i_pixel_index % 13'd96;
  assign w_y   = i_pixel_index / 13'd96;
  assign w_top = 13'd64 - {7'd0, r_disp_level, 2'b00};
  assign w_lit = (w_y < 13'd64) && (w_x >= LP_X0) && (w_x <= LP_X1) && (w_y >= w_top);

  // Colour band by row for lit pixels, black otherwise.
  always_comb begin
    w_colour = C_BLACK;
    if (w_lit) begin
      if (w_y < 13'd16)      w_colour = C_RED;
      else if (w_y < 13'd32) w_colour = C_YELLOW;
      else                   w_colour = C_GREEN;
    end
  end

  // One-cycle registered pixel output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pixel_data <= C_BLACK;
    end else begin
      r_pixel_data <= w_colour;
    end
  end

  assign o_pixel_data = r_pixel_data;
  assign o_level      = r_level;

endmodule

// File: tb/tb_oled_volume_bar.sv
// tb/tb_oled_volume_bar.sv - randomized and directed checks of oled_volume_bar against a behavioural model
module tb_oled_volume_bar;

  localparam int WINDOW = 1200;
  localparam int OFF    = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mic_in = '0;
  logic        mic_valid = 1'b0;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] pixel_data;
  logic [3:0]  level;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  oled_volume_bar #(.WINDOW(WINDOW), .MIC_OFFSET(OFF), .BAR_X0(40), .BAR_X1(55)) dut (
    .i_clk(clk), .i_reset(reset), .i_mic_in(mic_in), .i_mic_valid(mic_valid),
    .i_frame_begin(frame_begin), .i_pixel_index(pixel_index),
    .o_pixel_data(pixel_data), .o_level(level)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int q[$];
  int m_level = 0;
  int m_disp  = 0;
  int m_pix   = 0;

  function automatic int exp_pix(int idx, int d);
    int x, y;
    if (idx >= 6144) return 0;
    x = idx % 96;
    y = idx / 96;
    if (x < 40 || x > 55 || y < 64 - 4 * d) return 0;
    if (y < 16) return 'hF800;
    if (y < 32) return 'hFFE0;
    return 'h07E0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_level = 0; m_disp = 0; m_pix = 0;
    end else begin
      int pk;
      m_pix = exp_pix(int'(pixel_index), m_disp);
      if (frame_begin) m_disp = m_level;
      if (mic_valid) begin
        q.push_back(int'(mic_in));
        if (q.size() == WINDOW) begin
          pk = 0;
          foreach (q[i]) if (q[i] > pk) pk = q[i];
          if (pk <= OFF) m_level = 0;
          else m_level = ((pk - OFF) / 128 > 15) ? 15 : (pk - OFF) / 128;
          q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (int'(level) != m_level) begin
        n_errors++;
        $display("FAIL model_level t=%0t got %0d want %0d", $time, level, m_level);
      end
      n_checks++;
      if (int'(pixel_data) != m_pix) begin
        n_errors++;
        $display("FAIL model_pixel t=%0t idx=%0d got %h want %h", $time, pixel_index, pixel_data, m_pix[15:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic strobes(int val, int n);
    for (int i = 0; i < n; i++) begin
      mic_in = 12'(val); mic_valid = 1'b1;
      tick();
    end
    mic_valid = 1'b0;
  endtask

  task automatic frame();
    frame_begin = 1'b1; tick(); frame_begin = 1'b0;
  endtask

  task automatic pix(string name, int idx, int exp);
    pixel_index = 13'(idx); tick();
    check(name, int'(pixel_data), exp);
  endtask

  initial begin
    int amp;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_level", int'(level), 0);
    check("reset_pixel", int'(pixel_data), 0);

    // Full window of max samples, then partial window cut by reset
    strobes('hFFF, WINDOW);
    check("full_window_level", int'(level), 15);
    strobes('hFFF, 1000);
    reset = 1'b1; repeat (3) tick(); reset = 1'b0;
    check("midreset_level", int'(level), 0);
    check("midreset_pixel", int'(pixel_data), 0);
    strobes('hFFF, WINDOW - 1);
    check("needs_full_window", int'(level), 0);
    strobes('hFFF, 1);
    check("level_after_last", int'(level), 15);
    check("peak_cleared", int'(dut.r_peak), 0);
    check("cnt_cleared", int'(dut.r_cnt), 0);

    // Quantisation
    strobes(2000, WINDOW - 1);
    strobes(2688, 1);
    check("level5", int'(level), 5);
    strobes(2048, WINDOW);
    check("level0_silence", int'(level), 0);
    strobes(2688, 1);
    strobes(100, WINDOW - 1);
    check("level5_first", int'(level), 5);

    // Bar for level 5
    frame();
    pix("l5_lit", 44 + 96 * 44, 'h07E0);
    pix("l5_above", 44 + 96 * 43, 0);
    pix("l5_leftcol", 39 + 96 * 63, 0);

    // Bar for level 15
    strobes('hFFF, WINDOW);
    frame();
    pix("l15_red", 40 + 96 * 10, 'hF800);
    pix("l15_yellow", 55 + 96 * 20, 'hFFE0);
    pix("l15_row3", 40 + 96 * 3, 0);
    pix("l15_oob", 6200, 0);

    // Window completes together with frame_begin
    strobes(2048 + 3 * 128, WINDOW);
    frame();
    strobes(2048 + 9 * 128, WINDOW - 1);
    mic_in = 12'(2048 + 9 * 128); mic_valid = 1'b1; frame_begin = 1'b1;
    tick();
    mic_valid = 1'b0; frame_begin = 1'b0;
    check("coincide_level", int'(level), 9);
    pix("coincide_old_lit", 44 + 96 * 52, 'h07E0);
    pix("coincide_old_dark", 44 + 96 * 51, 0);
    frame();
    pix("next_frame_new", 44 + 96 * 30, 'hFFE0);

    // Randomized traffic
    amp = 2500;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) amp = $urandom_range(1800, 4095);
      mic_valid   = ($urandom_range(0, 3) != 0);
      mic_in      = 12'($urandom_range(0, amp));
      frame_begin = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0)
        pixel_index = 13'($urandom_range(0, 6300));
      else
        pixel_index = 13'($urandom_range(36, 59) + 96 * $urandom_range(0, 63));
      reset = ($urandom_range(0, 2999) == 0);
      tick();
    end
    reset = 1'b0; mic_valid = 1'b0; frame_begin = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
